// File: rtl/univ_bound_counter_if.sv
// Control/status bundle for one univ_bound_counter channel.
// There is no valid/ready handshake: every control is a level sampled on each
// rising clk edge, and every status output is valid whenever it is looked at.
interface univ_bound_counter_if #(
    parameter int N = 8
);
    // Controls (driven by the channel owner)
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic         sat;
    logic [N-1:0] step;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [N-1:0] d;

    // Status (driven by the counter)
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         evt;
    logic         ovf_sticky;
    logic         unf_sticky;
    logic         cfg_err;

    modport master (
        output syn_clr, load, en, up, sat, step, lo, hi, d,
        input  q, max_tick, min_tick, evt, ovf_sticky, unf_sticky, cfg_err
    );

    modport slave (
        input  syn_clr, load, en, up, sat, step, lo, hi, d,
        output q, max_tick, min_tick, evt, ovf_sticky, unf_sticky, cfg_err
    );
endinterface

// File: rtl/univ_bound_counter.sv
// Bounded up/down counter with programmable lo/hi bounds, variable step,
// wrap or saturate overflow handling, a registered crossing-event pulse and
// sticky overflow/underflow flags. One instance per count channel.
module univ_bound_counter #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    univ_bound_counter_if.slave   bus
);

    // Which action the current edge will perform; kept as a named signal so
    // checkers and waveforms can see the decision directly.
    typedef enum logic [2:0] {
        ACT_IDLE   = 3'd0,
        ACT_CLR    = 3'd1,
        ACT_LOAD   = 3'd2,
        ACT_RECOV  = 3'd3,
        ACT_STEP   = 3'd4,
        ACT_OVF    = 3'd5,
        ACT_UNF    = 3'd6,
        ACT_HOLD   = 3'd7
    } act_t;

    logic [N-1:0] q_r;
    logic         evt_r;
    logic         ovf_r;
    logic         unf_r;

    logic [N-1:0] q_nxt;
    logic         evt_nxt;
    logic         ovf_nxt;
    logic         unf_nxt;
    act_t         act;

    logic         cfg_err;
    logic         in_range;
    logic [N:0]   sum_up;
    logic [N:0]   lo_plus_step;
    logic [N-1:0] diff_dn;
    logic [N-1:0] load_val;

    // Configuration check and range/arithmetic helpers. Sums are one bit
    // wider than the counter so a carry past 2^N is still seen as > hi.
    always_comb begin
        cfg_err      = (bus.hi < bus.lo);
        in_range     = (q_r >= bus.lo) && (q_r <= bus.hi);
        sum_up       = {1'b0, q_r} + {1'b0, bus.step};
        lo_plus_step = {1'b0, bus.lo} + {1'b0, bus.step};
        diff_dn      = q_r - bus.step;
        if (bus.d > bus.hi) begin
            load_val = bus.hi;
        end else if (bus.d < bus.lo) begin
            load_val = bus.lo;
        end else begin
            load_val = bus.d;
        end
    end

    // Decide this edge's single action by priority: clear > load > count.
    always_comb begin
        act = ACT_IDLE;
        if (bus.syn_clr) begin
            act = ACT_CLR;
        end else if (cfg_err) begin
            act = ACT_IDLE;
        end else if (bus.load) begin
            act = ACT_LOAD;
        end else if (bus.en) begin
            if (!in_range) begin
                act = ACT_RECOV;
            end else if (bus.step == '0) begin
                act = ACT_HOLD;
            end else if (bus.up) begin
                act = (sum_up <= {1'b0, bus.hi}) ? ACT_STEP : ACT_OVF;
            end else begin
                act = ({1'b0, q_r} >= lo_plus_step) ? ACT_STEP : ACT_UNF;
            end
        end
    end

    // Next-state values for the chosen action; evt is a one-edge pulse, so it
    // defaults low and only crossing/recovery actions raise it.
    always_comb begin
        q_nxt   = q_r;
        evt_nxt = 1'b0;
        ovf_nxt = ovf_r;
        unf_nxt = unf_r;
        case (act)
            ACT_CLR: begin
                q_nxt   = bus.lo;
                ovf_nxt = 1'b0;
                unf_nxt = 1'b0;
            end
            ACT_LOAD: begin
                q_nxt = load_val;
            end
            ACT_RECOV: begin
                q_nxt   = bus.lo;
                evt_nxt = 1'b1;
            end
            ACT_STEP: begin
                q_nxt = bus.up ? sum_up[N-1:0] : diff_dn;
            end
            ACT_OVF: begin
                // Wrap lands on the opposite bound; excess is discarded.
                q_nxt   = bus.sat ? bus.hi : bus.lo;
                evt_nxt = 1'b1;
                ovf_nxt = 1'b1;
            end
            ACT_UNF: begin
                q_nxt   = bus.sat ? bus.lo : bus.hi;
                evt_nxt = 1'b1;
                unf_nxt = 1'b1;
            end
            default: begin
                q_nxt = q_r;
            end
        endcase
    end

    // State register with synchronous reset overriding every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= '0;
            evt_r <= 1'b0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            evt_r <= evt_nxt;
            ovf_r <= ovf_nxt;
            unf_r <= unf_nxt;
        end
    end

    // Status outputs; bound ticks follow q combinationally and are suppressed
    // while the bounds are inconsistent.
    always_comb begin
        bus.q          = q_r;
        bus.evt        = evt_r;
        bus.ovf_sticky = ovf_r;
        bus.unf_sticky = unf_r;
        bus.cfg_err    = cfg_err;
        bus.max_tick   = (q_r == bus.hi) && !cfg_err;
        bus.min_tick   = (q_r == bus.lo) && !cfg_err;
    end

endmodule

// File: tb/tb_univ_bound_counter.sv
// Directed bench for univ_bound_counter (N=4) with hand-computed expectations.
module tb_univ_bound_counter;

    localparam int N = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    univ_bound_counter_if #(.N(N)) bus ();

    univ_bound_counter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoring
    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int lo_v, input int hi_v, input int step_v,
                           input logic up_v, input logic sat_v);
        bus.lo   = N'(lo_v);
        bus.hi   = N'(hi_v);
        bus.step = N'(step_v);
        bus.up   = up_v;
        bus.sat  = sat_v;
    endtask

    task automatic do_load(input int d_v);
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.d    = N'(d_v);
        tick();
        bus.load = 1'b0;
    endtask

    task automatic chk_q_evt(input string tag, input int q_e, input int evt_e);
        check({tag, ".q"}, int'(bus.q), q_e);
        check({tag, ".evt"}, int'(bus.evt), evt_e);
    endtask

    int exp_up_seq[4]  = '{2, 5, 8, 2};
    int exp_up_evt[4]  = '{1, 0, 0, 1};
    int exp_dn_seq[4]  = '{4, 2, 2, 2};
    int exp_dn_evt[4]  = '{0, 1, 1, 1};

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.syn_clr  = 1'b0;
        bus.load     = 1'b0;
        bus.en       = 1'b0;
        bus.d        = '0;
        set_cfg(0, 0, 0, 1'b1, 1'b0);
        tick();
        tick();
        check("rst.q", int'(bus.q), 0);
        check("rst.evt", int'(bus.evt), 0);
        check("rst.ovf", int'(bus.ovf_sticky), 0);
        check("rst.unf", int'(bus.unf_sticky), 0);
        reset = 1'b0;

        // Up/wrap with out-of-range recovery from 0
        set_cfg(2, 9, 3, 1'b1, 1'b0);
        bus.en = 1'b1;
        #1;
        check("up.max0", int'(bus.max_tick), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_q_evt($sformatf("up[%0d]", i), exp_up_seq[i], exp_up_evt[i]);
            check($sformatf("up[%0d].max", i), int'(bus.max_tick), 0);
        end
        check("up.ovf", int'(bus.ovf_sticky), 1);
        check("up.unf", int'(bus.unf_sticky), 0);

        // Down/saturate
        do_load(7);
        chk_q_evt("dn.load", 7, 0);
        set_cfg(2, 9, 3, 1'b0, 1'b1);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_q_evt($sformatf("dn[%0d]", i), exp_dn_seq[i], exp_dn_evt[i]);
            check($sformatf("dn[%0d].min", i), int'(bus.min_tick), (i >= 1) ? 1 : 0);
        end
        check("dn.unf", int'(bus.unf_sticky), 1);
        bus.en = 1'b0;
        tick();
        chk_q_evt("dn.idle", 2, 0);

        // Load clamp
        do_load(15);
        chk_q_evt("ld15", 9, 0);
        check("ld15.max", int'(bus.max_tick), 1);
        do_load(0);
        chk_q_evt("ld0", 2, 0);
        check("ld0.min", int'(bus.min_tick), 1);
        do_load(6);
        chk_q_evt("ld6", 6, 0);
        check("ld.ovf_kept", int'(bus.ovf_sticky), 1);

        // Priority: syn_clr beats load and en
        bus.syn_clr = 1'b1;
        bus.load    = 1'b1;
        bus.en      = 1'b1;
        bus.d       = 4'd8;
        tick();
        chk_q_evt("clr", 2, 0);
        check("clr.ovf", int'(bus.ovf_sticky), 0);
        check("clr.unf", int'(bus.unf_sticky), 0);
        bus.syn_clr = 1'b0;
        reset       = 1'b1;
        bus.en      = 1'b0;
        tick();
        check("rst_ld.q", int'(bus.q), 0);
        reset    = 1'b0;
        bus.load = 1'b0;
        bus.en   = 1'b1;
        tick();
        chk_q_evt("rst_rec", 2, 1);
        bus.en = 1'b0;

        // Full-range carry into bit N, then step = 0
        set_cfg(0, 15, 1, 1'b1, 1'b0);
        do_load(14);
        chk_q_evt("fr.load", 14, 0);
        bus.en = 1'b1;
        tick();
        chk_q_evt("fr.15", 15, 0);
        check("fr.max", int'(bus.max_tick), 1);
        tick();
        chk_q_evt("fr.wrap", 0, 1);
        check("fr.ovf", int'(bus.ovf_sticky), 1);
        bus.step = 4'd0;
        tick();
        chk_q_evt("fr.step0", 0, 0);
        bus.en = 1'b0;

        // Config error
        do_load(3);
        chk_q_evt("ce.pre", 3, 0);
        set_cfg(5, 3, 1, 1'b1, 1'b0);
        #1;
        check("ce.flag", int'(bus.cfg_err), 1);
        check("ce.max", int'(bus.max_tick), 0);
        check("ce.min", int'(bus.min_tick), 0);
        bus.en   = 1'b1;
        bus.load = 1'b1;
        bus.d    = 4'd7;
        tick();
        chk_q_evt("ce.hold", 3, 0);
        bus.load    = 1'b0;
        bus.syn_clr = 1'b1;
        tick();
        chk_q_evt("ce.clr", 5, 0);
        bus.syn_clr = 1'b0;
        bus.hi      = 4'd9;
        #1;
        check("ce.off", int'(bus.cfg_err), 0);
        check("ce.min_back", int'(bus.min_tick), 1);
        tick();
        chk_q_evt("ce.resume", 6, 0);
        bus.en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
